// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared operation codes, FSM state encoding and op-class helpers for the
// HI/LO multiply/divide controller.
package hilo_muldiv_ctrl_pkg;

   localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
   localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
   localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
   localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
   localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
   localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
   localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   function automatic logic is_mul_op(input logic [7:0] op);
      return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP);
   endfunction

   function automatic logic is_div_op(input logic [7:0] op);
      return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
   endfunction

   function automatic logic is_signed_op(input logic [7:0] op);
      return (op == EXE_MULT_OP) || (op == EXE_DIV_OP);
   endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_div_radix2.sv
// Iterative restoring unsigned divider: one quotient bit per cycle, WIDTH cycles.
// done_o flags the final iteration; quot_o/rem_o carry that iteration's result.
module div_radix2 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             done_o,
   output logic [WIDTH-1:0] quot_o,
   output logic [WIDTH-1:0] rem_o
);

   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] rem_q, quo_q, dvs_q, rem_d, quo_d;
   logic [CW-1:0]    cnt_q;
   logic             run_q;
   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] diff;

   always_comb begin
      shifted = {rem_q, quo_q[WIDTH-1]};
      diff    = {1'b0, shifted} - {2'b00, dvs_q};
      if (!diff[WIDTH+1]) begin
         rem_d = diff[WIDTH-1:0];
         quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
         rem_d = shifted[WIDTH-1:0];
         quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
   end

   assign done_o = run_q && (cnt_q == CW'(WIDTH - 1));
   assign quot_o = quo_d;
   assign rem_o  = rem_d;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (abort_i) begin
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (start_i) begin
         rem_q <= '0;
         quo_q <= dividend_i;
         dvs_q <= divisor_i;
         cnt_q <= '0;
         run_q <= 1'b1;
      end else if (run_q) begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         if (done_o) begin
            cnt_q <= '0;
            run_q <= 1'b0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// EX-stage multiply/divide sequencer and architectural HI/LO register pair.
// Holds the pipeline while a MULT/DIV is in flight and serves MFHI/MFLO reads.
module hilo_muldiv_ctrl
   import hilo_muldiv_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [7:0]       alucontrol,
   input  logic             start,
   input  logic             flush,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             stall,
   output logic [WIDTH-1:0] hilo_rdata,
   output logic             busy,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   state_e                  state_q;
   logic [WIDTH-1:0]        a_q, b_q, hi_q, lo_q, hi_d, lo_d;
   logic                    sgn_q;
   logic                    op_mul, op_div, div_ok, take_op, accept, div_done;
   logic [WIDTH-1:0]        div_quot, div_rem, quot_fix, rem_fix;
   logic signed [2*WIDTH-1:0] mul_a, mul_b, mul_p;

   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? -v : v;
   endfunction

   assign op_mul  = is_mul_op(alucontrol);
   assign op_div  = is_div_op(alucontrol);
   assign div_ok  = op_div && (src_b != '0);
   assign take_op = (state_q == S_IDLE) && start && (op_mul || div_ok);
   assign accept  = take_op && !flush;
   assign stall   = !flush && (take_op || (state_q == S_MUL) || (state_q == S_DIV));
   assign busy    = (state_q != S_IDLE);

   // Sign-extending to 2*WIDTH makes the low half of one product serve both MULT and MULTU.
   assign mul_a = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
   assign mul_b = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
   assign mul_p = mul_a * mul_b;

   div_radix2 #(.WIDTH(WIDTH)) u_div (
      .clk        (clk),
      .resetn     (resetn),
      .start_i    (accept && op_div),
      .abort_i    (flush),
      .dividend_i (abs_val(src_a, is_signed_op(alucontrol))),
      .divisor_i  (abs_val(src_b, is_signed_op(alucontrol))),
      .done_o     (div_done),
      .quot_o     (div_quot),
      .rem_o      (div_rem)
   );

   assign quot_fix = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -div_quot : div_quot;
   assign rem_fix  = (sgn_q && a_q[WIDTH-1]) ? -div_rem : div_rem;

   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (!flush) begin
         case (state_q)
            S_IDLE: begin
               if (start && (alucontrol == EXE_MTHI_OP)) hi_d = src_a;
               if (start && (alucontrol == EXE_MTLO_OP)) lo_d = src_a;
            end
            S_MUL:   {hi_d, lo_d} = mul_p;
            S_DIV: begin
               if (div_done) begin
                  lo_d = quot_fix;
                  hi_d = rem_fix;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
         if (flush) begin
            state_q <= S_IDLE;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (accept) begin
                     a_q     <= src_a;
                     b_q     <= src_b;
                     sgn_q   <= is_signed_op(alucontrol);
                     state_q <= op_mul ? S_MUL : S_DIV;
                  end
               end
               S_MUL:   state_q <= S_DONE;
               S_DIV:   if (div_done) state_q <= S_DONE;
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign hi_o       = hi_q;
   assign lo_o       = lo_q;
   assign hilo_rdata = (alucontrol == EXE_MFHI_OP) ? hi_q :
                       (alucontrol == EXE_MFLO_OP) ? lo_q : '0;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl: MULT/DIV results, stall lengths,
// MTHI/MTLO/MFHI/MFLO, divide-by-zero, flush and mid-operation reset.
module tb_hilo_muldiv_ctrl;
   import hilo_muldiv_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        resetn, start, flush;
   logic [7:0]  alucontrol;
   logic [31:0] src_a, src_b, hilo_rdata, hi_o, lo_o;
   logic        stall, busy;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [63:0] sb_q[$];
   logic [31:0] m_hi, m_lo;

   always #5 clk = ~clk;

   hilo_muldiv_ctrl #(.WIDTH(32)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .alucontrol (alucontrol),
      .start      (start),
      .flush      (flush),
      .src_a      (src_a),
      .src_b      (src_b),
      .stall      (stall),
      .hilo_rdata (hilo_rdata),
      .busy       (busy),
      .hi_o       (hi_o),
      .lo_o       (lo_o)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_hilo, input int exp_stall);
      int          ns  = 0;
      int          cyc = 0;
      bit          done = 1'b0;
      logic [63:0] e;
      alucontrol = op; src_a = a; src_b = b; start = 1'b1;
      sb_q.push_back(exp_hilo);
      while (!done && cyc < 100) begin
         @(negedge clk);
         if (stall) ns++;
         if (busy && !stall) done = 1'b1;
         else cyc++;
      end
      check_val({tag, " reached_done"}, 64'(done), 64'd1);
      e = sb_q.pop_front();
      check_val({tag, " hilo"}, {hi_o, lo_o}, e);
      check_val({tag, " stall_cycles"}, 64'(ns), 64'(exp_stall));
      m_hi = e[63:32];
      m_lo = e[31:0];
      @(posedge clk); #1;
      start = 1'b0; alucontrol = 8'h00;
      @(negedge clk);
      check_val({tag, " idle_after"}, 64'(busy), 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [7:0]  op;
      logic [31:0] a, b;
      logic [63:0] exp;
      int          k;
      longint      sa, sb;
      longint unsigned ua, ub;
      int          ia, ib;

      resetn = 1'b0; start = 1'b0; flush = 1'b0;
      alucontrol = EXE_MFHI_OP; src_a = '0; src_b = '0;
      m_hi = '0; m_lo = '0;
      #12;
      check_val("reset stall", 64'(stall), 64'd0);
      check_val("reset busy", 64'(busy), 64'd0);
      check_val("reset hilo", {hi_o, lo_o}, 64'd0);
      check_val("reset rdata", 64'(hilo_rdata), 64'd0);
      #3 resetn = 1'b1;
      alucontrol = 8'h00;
      @(posedge clk); #1;

      run_op("mult_neg3x5", EXE_MULT_OP, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 2);
      run_op("multu_max", EXE_MULTU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 2);
      run_op("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
      run_op("div_m7_2", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
      run_op("div_ovf", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);

      for (int i = 0; i < 8; i++) begin
         k = i % 4;
         a = $urandom;
         b = $urandom;
         if (b == 0) b = 32'd9;
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
         case (k)
            0: begin
               op = EXE_MULT_OP; sa = longint'($signed(a)); sb = longint'($signed(b));
               exp = 64'(sa * sb);
            end
            1: begin
               op = EXE_MULTU_OP; ua = longint'(a); ub = longint'(b);
               exp = 64'(ua * ub);
            end
            2: begin
               op = EXE_DIV_OP; ia = $signed(a); ib = $signed(b);
               exp = {32'(ia % ib), 32'(ia / ib)};
            end
            default: begin
               op = EXE_DIVU_OP;
               exp = {a % b, a / b};
            end
         endcase
         run_op($sformatf("rand%0d", i), op, a, b, exp, (k < 2) ? 2 : 33);
      end

      // divide by zero: no stall, HI/LO untouched
      alucontrol = EXE_DIV_OP; src_a = 32'd55; src_b = 32'd0; start = 1'b1;
      @(negedge clk);
      check_val("div0 stall", 64'(stall), 64'd0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check_val("div0 busy", 64'(busy), 64'd0);
      check_val("div0 hilo", {hi_o, lo_o}, {m_hi, m_lo});
      @(posedge clk); #1;

      // MTHI then MFHI next cycle
      alucontrol = EXE_MTHI_OP; src_a = 32'h1234_5678; start = 1'b1;
      @(negedge clk);
      check_val("mthi stall", 64'(stall), 64'd0);
      @(posedge clk); #1;
      alucontrol = EXE_MFHI_OP;
      m_hi = 32'h1234_5678;
      @(negedge clk);
      check_val("mfhi rdata", 64'(hilo_rdata), 64'(m_hi));
      @(posedge clk); #1;
      alucontrol = EXE_MTLO_OP; src_a = 32'hCAFE_F00D;
      @(posedge clk); #1;
      alucontrol = EXE_MFLO_OP;
      m_lo = 32'hCAFE_F00D;
      @(negedge clk);
      check_val("mflo rdata", 64'(hilo_rdata), 64'(m_lo));
      @(posedge clk); #1;

      // flushed MTLO must not write
      alucontrol = EXE_MTLO_OP; src_a = 32'h0000_DEAD; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; alucontrol = EXE_MFLO_OP;
      @(negedge clk);
      check_val("flushed mtlo", 64'(hilo_rdata), 64'(m_lo));
      alucontrol = EXE_MULT_OP; start = 1'b0;
      #1 check_val("rdata non-mf", 64'(hilo_rdata), 64'd0);
      @(posedge clk); #1;

      // flush at DIV cycle 10
      alucontrol = EXE_DIVU_OP; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
      end
      flush = 1'b1;
      @(negedge clk);
      check_val("flush stall_drop", 64'(stall), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0; start = 1'b0;
      @(negedge clk);
      check_val("flush idle", 64'(busy), 64'd0);
      check_val("flush hilo", {hi_o, lo_o}, {m_hi, m_lo});
      for (int c = 0; c < 40; c++) @(negedge clk);
      check_val("flush hilo_late", {hi_o, lo_o}, {m_hi, m_lo});
      @(posedge clk); #1;

      // reset mid-divide
      alucontrol = EXE_DIV_OP; src_a = 32'd77; src_b = 32'd5; start = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
      end
      resetn = 1'b0; start = 1'b0;
      #1;
      check_val("rst_mid hilo", {hi_o, lo_o}, 64'd0);
      check_val("rst_mid stall", 64'(stall), 64'd0);
      check_val("rst_mid busy", 64'(busy), 64'd0);
      #3 resetn = 1'b1;
      @(posedge clk); #1;
      run_op("post_reset_divu", EXE_DIVU_OP, 32'd77, 32'd5, {32'd2, 32'd15}, 33);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
